// File: rtl/imcol_state_serial.sv
// Serialized inverse MixColumns for one share of the 160-bit Fides state.
// LANES column groups are mixed per cycle while the state register rotates left.
module imcol_state_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [159:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_data,
  output logic         busy
);

  localparam int GW     = 20;
  localparam int STEP   = GW * LANES;
  localparam int PASSES = 8 / LANES;
  localparam logic [2:0] LAST = 3'(PASSES - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("imcol_state_serial: LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [159:0] data_reg, data_next;
  logic [2:0]   cnt_reg, cnt_next;

  logic [STEP-1:0] mixed_top;
  logic [159:0]    rotated;

  // (J+I) is involutory: each output word is the column XOR with itself removed.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [GW-1:0] grp;
    logic [4:0]    s;
    assign grp = data_reg[159-GW*gi -: GW];
    assign s   = grp[19:15] ^ grp[14:10] ^ grp[9:5] ^ grp[4:0];
    assign mixed_top[STEP-1-GW*gi -: GW] = {s ^ grp[19:15], s ^ grp[14:10],
                                            s ^ grp[9:5],   s ^ grp[4:0]};
  end

  if (STEP == 160) begin : g_rot_full
    assign rotated = mixed_top;
  end else begin : g_rot_part
    assign rotated = {data_reg[159-STEP:0], mixed_top};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next = data_reg;
    cnt_next  = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (in_valid) data_next = in_data;
      end
      RUN: begin
        data_next = rotated;
        cnt_next  = (cnt_reg == LAST) ? 3'd0 : cnt_reg + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg == RUN) || (state_reg == DONE);
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_imcol_state_serial.sv
// Bench for imcol_state_serial: one instance per legal LANES value, table vectors,
// directed corner sequences and a scoreboarded random regression on LANES=1.
module tb_imcol_state_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [4];
  logic [159:0] in_data   [4];
  logic         out_ready [4];
  logic         in_ready_w  [4];
  logic         out_valid_w [4];
  logic [159:0] out_data_w  [4];
  logic         busy_w      [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    imcol_state_serial #(.LANES(1 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready_w[gi]),
      .in_data   (in_data[gi]),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data_w[gi]),
      .busy      (busy_w[gi])
    );
  end

  typedef struct {
    logic [159:0] din;
    logic [159:0] exp;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [159:0] sb[$];
  int got_cnt, mon_cyc;

  function automatic logic [159:0] ref_mix(input logic [159:0] x);
    logic [159:0] r;
    logic [19:0]  g20;
    logic [4:0]   s;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      g20 = x[159-20*g -: 20];
      s = g20[19:15] ^ g20[14:10] ^ g20[9:5] ^ g20[4:0];
      r[159-20*g -: 20] = {s ^ g20[19:15], s ^ g20[14:10], s ^ g20[9:5], s ^ g20[4:0]};
    end
    return r;
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [159:0] got);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: output with empty scoreboard, got %h", name, got);
    end else begin
      chk(name, got, sb.pop_front());
    end
  endtask

  // One full transaction with out_ready held high; checks latency and data.
  task automatic run_txn(input int k, input logic [159:0] din, input logic [159:0] exp,
                         input string name);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready"}, 160'(in_ready_w[k]), 160'd1);
    in_data[k]   = din;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid_w[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 160'(lat), 160'(8 >> k));
    pop_chk({name, "_data"}, out_data_w[k]);
    @(negedge clk);
    chk({name, "_valid_drop"}, 160'(out_valid_w[k]), 160'd0);
    chk({name, "_ready_back"}, 160'(in_ready_w[k]), 160'd1);
    $display("[TB] lanes=%0d %s in=%h out=%h lat=%0d", 1 << k, name, din, exp, lat);
  endtask

  initial begin
    vec_t vecs[4];
    logic [159:0] x, hold, e;
    int t;

    vecs[0].din = 160'h08000 << 140;  vecs[0].exp = 160'h00421 << 140;
    vecs[1].din = '1;                 vecs[1].exp = '1;
    vecs[2].din = 160'h08888;         vecs[2].exp = 160'h73567;
    vecs[3].din = 160'h08000 << 80;   vecs[3].exp = 160'h00421 << 80;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", 160'(in_ready_w[k]), 160'd1);
      chk("rst_out_valid", 160'(out_valid_w[k]), 160'd0);
      chk("rst_busy", 160'(busy_w[k]), 160'd0);
      chk("rst_out_data", out_data_w[k], 160'd0);
    end

    // Data present without in_valid must not be taken.
    in_data[0] = '1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 160'(busy_w[0]), 160'd0);
    chk("idle_data", out_data_w[0], 160'd0);
    $display("[TB] idle hold busy=%0b data=%h", busy_w[0], out_data_w[0]);

    for (int k = 0; k < 4; k++)
      for (int v = 0; v < 4; v++)
        run_txn(k, vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v));

    for (int k = 0; k < 4; k++) begin
      x = rnd160();
      run_txn(k, x, ref_mix(x), "invol_a");
      run_txn(k, ref_mix(x), x, "invol_b");
    end

    // Backpressure on LANES=1.
    @(negedge clk);
    x = rnd160();
    in_data[0] = x; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    sb.push_back(ref_mix(x));
    @(negedge clk);
    in_valid[0] = 1'b0;
    t = 0;
    while (!out_valid_w[0] && t < 20) begin @(negedge clk); t++; end
    chk("bp_latency", 160'(t), 160'd8);
    hold = out_data_w[0];
    pop_chk("bp_data", hold);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = ~x;
      @(negedge clk);
      chk("bp_valid_hold", 160'(out_valid_w[0]), 160'd1);
      chk("bp_in_ready", 160'(in_ready_w[0]), 160'd0);
      chk("bp_data_hold", out_data_w[0], hold);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 160'(in_ready_w[0]), 160'd1);
    chk("bp_release_valid", 160'(out_valid_w[0]), 160'd0);
    @(negedge clk);
    chk("bp_no_accept", 160'(busy_w[0]), 160'd0);
    $display("[TB] backpressure held out=%h", hold);

    // Reset during the third RUN cycle, then a clean transaction.
    x = rnd160();
    in_data[0] = x; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy", 160'(busy_w[0]), 160'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_valid", 160'(out_valid_w[0]), 160'd0);
    chk("midrun_rst_busy", 160'(busy_w[0]), 160'd0);
    chk("midrun_rst_data", out_data_w[0], 160'd0);
    chk("midrun_rst_ready", 160'(in_ready_w[0]), 160'd1);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset mid-run discarded in=%h", x);
    x = rnd160();
    run_txn(0, x, ref_mix(x), "post_rst");

    // Random regression with gaps on both sides.
    got_cnt = 0;
    mon_cyc = 0;
    fork
      begin : drv
        logic [159:0] r;
        int w;
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          r = rnd160();
          in_data[0] = r; in_valid[0] = 1'b1;
          w = 0;
          while (!in_ready_w[0] && w < 200) begin @(negedge clk); w++; end
          if (w >= 200) begin
            tests++; fails++;
            $display("FAIL reg_accept_timeout: got in_ready=0 after %0d cycles, expected 1", w);
          end else begin
            sb.push_back(ref_mix(r));
          end
          @(negedge clk);
          in_valid[0] = 1'b0;
        end
      end
      begin : mon
        while (got_cnt < 1000 && mon_cyc < 60000) begin
          @(negedge clk);
          mon_cyc++;
          out_ready[0] = 1'($urandom_range(0, 1));
          if (out_valid_w[0] && out_ready[0]) begin
            pop_chk("reg_data", out_data_w[0]);
            $display("[TB] reg txn %0d out=%h", got_cnt, out_data_w[0]);
            got_cnt++;
          end
        end
      end
    join
    chk("reg_count", 160'(got_cnt), 160'd1000);
    chk("reg_sb_empty", 160'(sb.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imcol_state_serial.md
# imcol_state_serial

Serialized inverse MixColumns for the 160-bit Fides state, applied to one share of the threshold implementation. It accepts a full 160-bit state over a valid/ready handshake and processes LANES column groups per cycle through a rotating state register. It returns the transformed state over a second valid/ready handshake. It sits on the decryption datapath and trades the parallel mix-columns area for 8/LANES cycles of latency per state. Because the transform is linear, one instance is used per share with no share interaction.

## Interface
- LANES, default 1: column groups processed per cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  160  input state share.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  160  transformed state share, driven directly from the state register.
- busy  output  1  high in RUN or DONE.

## Operation
- Layout: the state holds 8 column groups. Group g occupies bits [159-20g : 140-20g], with g = 0 at the MSBs. Each group holds four 5-bit words w1..w4, with w1 at the group MSBs.
- Per-group function: s = w1^w2^w3^w4 and yi = s ^ wi. The Fides matrix (J+I) is involutory over GF(2^5), so this is the exact inverse. No field multiplication is needed.
- State machine, 2-bit state:
  - IDLE:
    - in_ready=1, out_valid=0.
    - When in_valid=1, load in_data into the register, clear the counter and go to RUN.
  - RUN:
    - in_ready=0.
    - Each cycle, transform the top LANES groups, i.e. bits [159 : 160-20·LANES].
    - Rotate the register left by 20·LANES bits, with the transformed groups wrapping into the LSBs.
    - Increment the counter.
    - After the 8/LANES-th RUN cycle, go to DONE. After a full pass, group order is restored.
  - DONE:
    - out_valid=1, in_ready=0.
    - The register holds its value.
    - When out_ready=1, go to IDLE.
- Counter: 3 bits, counts 0 .. 8/LANES-1. The RUN to DONE transition happens on the terminal count. The counter resets to 0 in IDLE.
- No overlap: in_valid is ignored outside IDLE, and a new state cannot be accepted in the same cycle as a result handshake.
- With LANES=8, RUN lasts exactly one cycle and the rotation is by 160, which is the identity.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - state=IDLE, register=0, counter=0.
  - in_ready=1, out_valid=0, busy=0.
  - out_data=0.
- Input handshake: occurs at the rising edge where in_valid and in_ready are both 1 (edge E).
- Latency: out_valid rises after edge E+8/LANES. That is 8 cycles for LANES=1 and 1 cycle for LANES=8.
- Output handshake: occurs at the edge where out_valid and out_ready are both 1. out_valid falls and in_ready rises on that same edge.
- Minimum state-to-state throughput: 8/LANES + 2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid hold indefinitely.
- Intermediate values: out_data in RUN shows the partially rotated register. It is don't-care and must be qualified by out_valid.
- Reset mid-RUN or mid-DONE: all outputs and registers return immediately to reset values and the partial result is discarded. After reset, the first in_valid is accepted normally.
- All outputs are registered or decoded from state only, with no combinational path from in_valid or out_ready.

## Test plan
- Reset then idle: rst pulse -> in_ready=1, out_valid=0, busy=0, out_data=0. Drive in_data=all-ones with in_valid=0 -> no state change.
- Unit vector, LANES=1: in_data = 160'h08000 << 140 (w1 of group 0 = 5'h01) -> out_valid exactly 8 cycles after accept, out_data = 160'h00421 << 140.
- All-ones: in_data = 160'hFF..FF -> out_data = all-ones. Random 160-bit X through two back-to-back transactions returns X (involution). Run for LANES = 1, 2, 4, 8 with latencies 8, 4, 2, 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, and in_valid pulses during this window are ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at the 3rd RUN cycle -> immediately out_valid=0, busy=0, out_data=0. A new state is then accepted and produces the correct result after 8 cycles.
- Random regression: 1000 random states with random in_valid/out_ready gaps, checked against a per-group reference model. Every group must match and no transaction may be dropped or duplicated.
